// File: rtl/gdsp_tx_scheduler.sv
// Sample/symbol scheduler for the 16-QAM TX chain: divider, zero-stuff phase, FIR flush FSM.
// Optional statistics counters are built when GDSP_SCHED_STATS_EN is defined.
module gdsp_tx_scheduler #(
   parameter int SPS       = 4,
   parameter int NUM_TAPS  = 33,
   parameter int DIV_WIDTH = 16,
   localparam int PHASE_W  = $clog2(SPS),
   localparam int FLUSH_W  = $clog2(NUM_TAPS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable_i,
   input  logic [DIV_WIDTH-1:0] clk_div_i,
   input  logic                 out_ready_i,
   output logic                 sample_tick_o,
   output logic                 sym_tick_o,
   output logic                 zero_stuff_o,
   output logic [PHASE_W-1:0]   phase_o,
   output logic                 busy_o,
   output logic                 flushing_o,
   output logic                 overrun_o
`ifdef GDSP_SCHED_STATS_EN
   ,
   output logic [31:0]          sym_count_o,
   output logic [15:0]          flush_count_o
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t               state;
   logic [DIV_WIDTH-1:0] div_cnt;
   logic [PHASE_W-1:0]   phase;
   logic [FLUSH_W-1:0]   flush_cnt;
   logic                 pending;
   logic                 expiry;
   logic                 fire;

   // pending is only ever set outside IDLE, so fire needs no extra state qualifier
   assign expiry = (state != IDLE) && (div_cnt == '0);
   assign fire   = (expiry || pending) && out_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         div_cnt       <= '0;
         phase         <= '0;
         flush_cnt     <= '0;
         pending       <= 1'b0;
         sample_tick_o <= 1'b0;
         sym_tick_o    <= 1'b0;
         zero_stuff_o  <= 1'b0;
         phase_o       <= '0;
         busy_o        <= 1'b0;
         flushing_o    <= 1'b0;
         overrun_o     <= 1'b0;
`ifdef GDSP_SCHED_STATS_EN
         sym_count_o   <= '0;
         flush_count_o <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments let a later branch (e.g. FLUSH exit) override
         // the default divider/pending update of the same edge; the last write wins.
         sample_tick_o <= fire;
         sym_tick_o    <= 1'b0;
         zero_stuff_o  <= 1'b0;
         busy_o        <= (state != IDLE);
         flushing_o    <= (state == FLUSH);

         if (out_ready_i) begin
            pending <= pending && expiry;
         end else if (expiry) begin
            pending <= 1'b1;
            if (pending) overrun_o <= 1'b1;
         end

         if (state != IDLE) begin
            div_cnt <= expiry ? clk_div_i : div_cnt - 1'b1;
         end

         case (state)
            IDLE: begin
               if (enable_i) begin
                  state   <= RUN;
                  div_cnt <= '0;
                  phase   <= '0;
               end
            end
            RUN: begin
               if (fire) begin
                  phase_o      <= phase;
                  sym_tick_o   <= (phase == '0);
                  zero_stuff_o <= (phase != '0);
                  phase        <= phase + 1'b1;
`ifdef GDSP_SCHED_STATS_EN
                  if (phase == '0) sym_count_o <= sym_count_o + 1'b1;
`endif
                  // stop only on a symbol boundary so no partial symbol enters the FIR
                  if ((phase == PHASE_W'(SPS - 1)) && !enable_i) begin
                     state     <= FLUSH;
                     flush_cnt <= '0;
                  end
               end
            end
            FLUSH: begin
               if (fire) begin
                  phase_o      <= '0;
                  zero_stuff_o <= 1'b1;
                  if (flush_cnt == FLUSH_W'(NUM_TAPS - 1)) begin
                     state     <= enable_i ? RUN : IDLE;
                     div_cnt   <= '0;
                     phase     <= '0;
                     pending   <= 1'b0;
                     flush_cnt <= '0;
`ifdef GDSP_SCHED_STATS_EN
                     flush_count_o <= flush_count_o + 1'b1;
`endif
                  end else begin
                     flush_cnt <= flush_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gdsp_tx_scheduler.sv
// Self-checking bench for gdsp_tx_scheduler: directed scenarios plus random traffic,
// every cycle compared against a tick/sample-count reference model.
module tb_gdsp_tx_scheduler;

   localparam int SPS       = 4;
   localparam int NUM_TAPS  = 33;
   localparam int DIV_WIDTH = 16;
   localparam int PHASE_W   = $clog2(SPS);

   logic                 clk       = 1'b0;
   logic                 rst_n     = 1'b0;
   logic                 enable    = 1'b0;
   logic [DIV_WIDTH-1:0] clk_div   = '0;
   logic                 out_ready = 1'b1;
   logic                 sample_tick_o, sym_tick_o, zero_stuff_o;
   logic [PHASE_W-1:0]   phase_o;
   logic                 busy_o, flushing_o, overrun_o;
`ifdef GDSP_SCHED_STATS_EN
   logic [31:0]          sym_count_o;
   logic [15:0]          flush_count_o;
`endif

   int total = 0;
   int bad   = 0;

   gdsp_tx_scheduler #(.SPS(SPS), .NUM_TAPS(NUM_TAPS), .DIV_WIDTH(DIV_WIDTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable_i      (enable),
      .clk_div_i     (clk_div),
      .out_ready_i   (out_ready),
      .sample_tick_o (sample_tick_o),
      .sym_tick_o    (sym_tick_o),
      .zero_stuff_o  (zero_stuff_o),
      .phase_o       (phase_o),
      .busy_o        (busy_o),
      .flushing_o    (flushing_o),
      .overrun_o     (overrun_o)
`ifdef GDSP_SCHED_STATS_EN
      ,
      .sym_count_o   (sym_count_o),
      .flush_count_o (flush_count_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: mode 0/1/2 = idle/run/flush, counted in cycles-to-expiry,
   // owed ticks, samples emitted since run start and flush samples remaining.
   int          m_mode, m_wait, m_owed, m_sample, m_left;
   bit          m_exp, m_fire;
   logic        e_tick = 0, e_sym = 0, e_zs = 0, e_busy = 0, e_flush = 0, e_ovr = 0;
   int          e_phase = 0;
   logic [31:0] e_syms = 0;
   logic [15:0] e_flushes = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_wait = 0; m_owed = 0; m_sample = 0; m_left = 0;
         e_tick = 0; e_sym = 0; e_zs = 0; e_phase = 0;
         e_busy = 0; e_flush = 0; e_ovr = 0; e_syms = 0; e_flushes = 0;
      end else begin
         m_exp   = (m_mode != 0) && (m_wait == 0);
         m_fire  = (m_exp || m_owed > 0) && out_ready && (m_mode != 0);
         e_tick  = m_fire;
         e_sym   = 0;
         e_zs    = 0;
         e_busy  = (m_mode != 0);
         e_flush = (m_mode == 2);
         if (m_exp && !out_ready && m_owed > 0) e_ovr = 1;
         m_owed = m_owed + int'(m_exp) - int'(m_fire);
         if (m_owed > 1) m_owed = 1;
         if (m_mode != 0) m_wait = m_exp ? int'(clk_div) : m_wait - 1;
         case (m_mode)
            0: if (enable) begin
               m_mode = 1; m_wait = 0; m_sample = 0;
            end
            1: if (m_fire) begin
               e_phase = m_sample % SPS;
               e_sym   = (e_phase == 0);
               e_zs    = !e_sym;
               if (e_sym) e_syms++;
               m_sample++;
               if ((m_sample % SPS == 0) && !enable) begin
                  m_mode = 2; m_left = NUM_TAPS;
               end
            end
            default: if (m_fire) begin
               e_phase = 0;
               e_zs    = 1;
               m_left--;
               if (m_left == 0) begin
                  m_mode = enable ? 1 : 0;
                  m_wait = 0; m_sample = 0; m_owed = 0;
                  e_flushes++;
               end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      check("sample_tick", 32'(sample_tick_o), 32'(e_tick));
      check("sym_tick",    32'(sym_tick_o),    32'(e_sym));
      check("zero_stuff",  32'(zero_stuff_o),  32'(e_zs));
      check("phase",       32'(phase_o),       32'(e_phase));
      check("busy",        32'(busy_o),        32'(e_busy));
      check("flushing",    32'(flushing_o),    32'(e_flush));
      check("overrun",     32'(overrun_o),     32'(e_ovr));
`ifdef GDSP_SCHED_STATS_EN
      check("sym_count",   sym_count_o,        e_syms);
      check("flush_count", 32'(flush_count_o), 32'(e_flushes));
`endif
   end

   task automatic wait_tick(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (sample_tick_o !== 1'b1 && n < budget);
      if (sample_tick_o !== 1'b1) check("tick_timeout", 32'(sample_tick_o), 1);
   endtask

   task automatic wait_sym(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sample_tick_o === 1'b1 && sym_tick_o === 1'b1) && n < budget);
      if (sym_tick_o !== 1'b1) check("sym_timeout", 32'(sym_tick_o), 1);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Enable from IDLE: no tick after E0, first tick (phase 0, symbol strobe) after E1.
   task automatic start_and_check(input string tag);
      enable = 1'b1;
      @(negedge clk);
      check({tag, "_no_tick_e0"}, 32'(sample_tick_o), 0);
      @(negedge clk);
      check({tag, "_tick_e1"},    32'(sample_tick_o), 1);
      check({tag, "_sym_e1"},     32'(sym_tick_o),    1);
      check({tag, "_phase_e1"},   32'(phase_o),       0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int nflush;
      int run_phases[$];
      bit done;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy",    32'(busy_o),        0);
      check("rst_tick",    32'(sample_tick_o), 0);
      check("rst_overrun", 32'(overrun_o),     0);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // clk_div = 0: tick every cycle
      clk_div = 0;
      out_ready = 1'b1;
      start_and_check("start0");
      repeat (20) @(negedge clk);

      // clk_div = 5: tick period 6, symbol period 24
      clk_div = 5;
      repeat (20) @(negedge clk);
      wait_tick(20, n);
      wait_tick(20, n);
      check("period_div5", n, 6);
      wait_sym(40, n);
      wait_sym(40, n);
      check("sym_period_div5", n, 24);

      // switch to clk_div = 2 mid-run; model tracks reload timing
      clk_div = 2;
      repeat (30) @(negedge clk);
      wait_tick(10, n);
      wait_tick(10, n);
      check("period_div2", n, 3);

      // drop enable at phase 1: phases 2,3 then exactly NUM_TAPS flush ticks
      n = 0;
      do begin
         wait_tick(10, nflush);
         n++;
      end while (phase_o !== PHASE_W'(1) && n < 10);
      check("found_phase1", 32'(phase_o), 1);
      enable = 1'b0;
      nflush = 0;
      done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (sample_tick_o === 1'b1) begin
            if (flushing_o === 1'b1) nflush++;
            else run_phases.push_back(int'(phase_o));
         end
         if (nflush > 0 && busy_o === 1'b0) done = 1;
      end
      check("tail_ticks", run_phases.size(), 2);
      if (run_phases.size() == 2) begin
         check("tail_phase_a", run_phases[0], 2);
         check("tail_phase_b", run_phases[1], 3);
      end
      check("flush_ticks", nflush, NUM_TAPS);
      check("idle_after_flush", 32'(busy_o), 0);

      // backpressure: one-cycle stall delays a tick, three-cycle stall overruns
      clk_div = 0;
      start_and_check("start1");
      repeat (10) @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
      check("stall_no_tick", 32'(sample_tick_o), 0);
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_resume", 32'(sample_tick_o), 1);
      repeat (5) @(negedge clk);
      check("no_overrun_1cyc", 32'(overrun_o), 0);
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("overrun_set", 32'(overrun_o), 1);
      repeat (20) @(negedge clk);
      check("overrun_sticky", 32'(overrun_o), 1);

      // reset at flush tick 10
      enable = 1'b0;
      nflush = 0;
      for (int i = 0; i < 200 && nflush < 10; i++) begin
         @(negedge clk);
         if (sample_tick_o === 1'b1 && flushing_o === 1'b1) nflush++;
      end
      check("reached_flush10", nflush, 10);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_tick",    32'(sample_tick_o), 0);
      check("midrst_busy",    32'(busy_o),        0);
      check("midrst_flush",   32'(flushing_o),    0);
      check("midrst_overrun", 32'(overrun_o),     0);
      check("midrst_zs",      32'(zero_stuff_o),  0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      start_and_check("restart");

`ifdef GDSP_SCHED_STATS_EN
      // 10 symbols then stop
      enable = 1'b0;
      pulse_reset();
      clk_div = 1;
      enable = 1'b1;
      n = 0;
      for (int i = 0; i < 400 && n < 10; i++) begin
         @(negedge clk);
         if (sample_tick_o === 1'b1 && sym_tick_o === 1'b1) n++;
      end
      enable = 1'b0;
      for (int i = 0; i < 400 && busy_o !== 1'b0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("stats_syms",    sym_count_o,        10);
      check("stats_flushes", 32'(flush_count_o), 1);
`endif

      // random traffic against the model
      pulse_reset();
      enable = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         out_ready = (($urandom % 8) != 0);
         if (($urandom % 64) == 0) enable = ~enable;
         if (($urandom % 128) == 0) clk_div = DIV_WIDTH'($urandom % 4);
      end
      enable = 1'b0;
      repeat (10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gdsp_tx_scheduler.md
Name: gdsp_tx_scheduler

Overview:
- Sequences the 16-QAM TX datapath: PRBS-23 LFSR advance, mapper, zero-stuff upsampler and 33-tap RRC FIR.
- Derives a sample-rate tick from the 27 MHz system clock via a programmable divider.
- Issues a symbol strobe every SPS samples and marks zero-stuff samples.
- On stop, flushes the FIR with NUM_TAPS zero samples so the filter tail drains cleanly before idling.

Parameters:
- SPS, 4, samples per symbol; power of two, 2..16.
- NUM_TAPS, 33, FIR length; sets the flush length in samples.
- DIV_WIDTH, 16, width of the sample-period divider.

Ports:
- clk  in  1  system clock, 27 MHz
- rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  run request, level-sensitive
- clk_div_i  in  DIV_WIDTH  sample period minus 1, in clk cycles
- out_ready_i  in  1  FIR/sink can accept a sample this cycle
- sample_tick_o  out  1  one-cycle strobe: FIR consumes one sample
- sym_tick_o  out  1  one-cycle strobe: LFSR emits 4 bits and mapper loads a symbol
- zero_stuff_o  out  1  qualifies sample_tick_o: FIR input is forced to 0
- phase_o  out  $clog2(SPS)  sample index within the current symbol
- busy_o  out  1  state != IDLE
- flushing_o  out  1  state == FLUSH
- overrun_o  out  1  sticky: a divider expiry occurred while a tick was still pending

Behaviour:
- Reset (async assert, sync deassert at the next clk edge):
  - state = IDLE; divider counter = 0; phase = 0; flush count = 0; pending = 0.
  - All outputs 0.
- All outputs are registered.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN: enable_i sampled high. Entering RUN loads the divider counter with 0 and phase with 0.
  - RUN -> FLUSH: enable_i low at a tick issued with phase == SPS-1. The current symbol always completes; no partial symbols.
  - FLUSH -> IDLE or RUN: after exactly NUM_TAPS ticks. Go to RUN if enable_i is high at that point, else IDLE. enable_i is ignored during FLUSH.
- Divider:
  - In RUN/FLUSH the counter decrements each cycle.
  - At 0 it "expires" and reloads from clk_div_i, which is sampled only at reload.
  - clk_div_i = 0 gives an expiry every cycle.
  - In IDLE the counter is held at 0.
- Tick issue:
  - A tick is issued on the clk edge where (expiry or pending) and out_ready_i are both high.
  - sample_tick_o is high for the following cycle only.
  - Expiry with out_ready_i low sets pending. pending clears when a tick is issued.
  - Expiry while pending is already set and out_ready_i is low: set overrun_o; the tick is not double-counted. overrun_o is cleared only by reset.
- Latency: enable_i high at edge E0 -> state RUN after E0 -> first sample_tick_o high after E1 (2 cycles). In that first tick phase_o = 0 and sym_tick_o = 1.
- Per-tick outputs in RUN:
  - sym_tick_o = (phase == 0).
  - zero_stuff_o = (phase != 0).
  - phase_o shows the phase of the current tick; phase increments mod SPS after each tick.
- Per-tick outputs in FLUSH: sym_tick_o = 0; zero_stuff_o = 1; phase_o = 0.
- sym_tick_o and zero_stuff_o are only meaningful while sample_tick_o = 1. Both are 0 otherwise.
- Steady state with out_ready_i held high gives a tick period of clk_div_i+1 cycles, and a symbol period of SPS*(clk_div_i+1) cycles.
- Simultaneous events:
  - Expiry in the same cycle a pending tick issues: pending stays set.
  - enable_i drop and FSM transition on the same edge: the rules above apply.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No flush is performed.

Optional Feature:
- Macro: GDSP_SCHED_STATS_EN.
- When defined:
  - Adds output sym_count_o, 32 bits, counting sym_tick_o pulses; wraps at 2^32.
  - Adds output flush_count_o, 16 bits, counting completed FLUSH episodes.
  - Both reset to 0 and are reset only by rst_n.
- When undefined: neither port nor its counters exist. All other behaviour is identical.

Test Plan:
- Reset release, enable_i=1, clk_div_i=0, out_ready_i=1:
  - First sample_tick_o 2 cycles after enable_i is sampled, with sym_tick_o=1, phase_o=0.
  - Ticks every cycle; sym_tick_o every 4th tick; zero_stuff_o on phases 1,2,3.
- clk_div_i=5:
  - sample_tick_o period 6 cycles, sym_tick_o period 24 cycles.
  - Change clk_div_i to 2 mid-run: the new period of 3 takes effect only after the next reload.
- Drop enable_i when phase_o=1:
  - Ticks for phases 2 and 3 follow, then exactly 33 ticks with zero_stuff_o=1, flushing_o=1, sym_tick_o=0.
  - Then busy_o=0.
- clk_div_i=0, out_ready_i low for 1 cycle: tick is delayed by one cycle, overrun_o stays 0. Hold out_ready_i low 3 cycles: overrun_o=1, sticky until reset.
- Assert rst_n low during FLUSH tick 10: all outputs 0 immediately. Re-enable: normal start with phase_o=0 and sym_tick_o=1.
- With GDSP_SCHED_STATS_EN defined: 10 symbols followed by a stop give sym_count_o=10 and flush_count_o=1.
